// File: rtl/int_divider_seq.sv
// Multi-cycle restoring radix-2 integer divider, signed or unsigned.
// Uses a start/busy/done handshake and flags divide-by-zero and signed MIN / -1.
module int_divider_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_ov;

  logic             w_accept;
  logic             w_sgn;
  logic             w_zero;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Operand conditioning for an accepted start
  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_sgn     = SIGNED_EN && signed_mode;
  assign w_zero    = (divisor == '0);
  assign w_dvd_neg = w_sgn && dividend[WIDTH-1];
  assign w_dvs_neg = w_sgn && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (WIDTH'(0) - dividend) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (WIDTH'(0) - divisor) : divisor;

  // One restoring step: the trial remainder is WIDTH+1 bits; the difference fits in WIDTH
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

  assign w_q_fix = r_neg_q ? (WIDTH'(0) - r_q) : r_q;
  assign w_r_fix = r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_zero ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? (w_zero ? S_FIX : S_CALC) : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_CALC, S_FIX: w_busy_nxt = 1'b1;
      S_DONE:        w_done_nxt = 1'b1;
      default:       ;
    endcase
  end

  // Datapath and registered outputs; a divide-by-zero keeps the raw dividend in r_q
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_ov        <= 1'b0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_done_nxt;
      if (w_accept) begin
        r_q     <= w_zero ? dividend : w_dvd_mag;
        r_dvs   <= w_dvs_mag;
        r_rem   <= '0;
        r_cnt   <= CW'(WIDTH - 1);
        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
        r_neg_r <= w_dvd_neg;
        r_dz    <= w_zero;
        r_ov    <= w_sgn && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
      end else if (r_state == S_CALC) begin
        r_q   <= {r_q[WIDTH-2:0], w_ge};
        r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
        r_cnt <= r_cnt - CW'(1);
      end else if (r_state == S_FIX) begin
        quotient    <= r_dz ? '1 : w_q_fix;
        remainder   <= r_dz ? r_q : w_r_fix;
        div_by_zero <= r_dz;
        overflow    <= r_ov;
      end
    end
  end

endmodule

// File: tb/tb_int_divider_seq.sv
// Randomised and directed bench for int_divider_seq: an 8-bit signed instance and a
// 16-bit unsigned-only instance, both checked every cycle against a behavioural model.
module tb_int_divider_seq;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st [2];
  logic        sm [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];

  logic        bz0, dn0, dz0, ov0, bz1, dn1, dz1, ov1;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;

  logic        obz [2];
  logic        odn [2];
  logic        odz [2];
  logic        oov [2];
  logic [31:0] oq  [2];
  logic [31:0] orr [2];

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   act [2];
  int   due [2];
  res_t cur [2];
  res_t pend[2];

  always #5 clk = ~clk;

  int_divider_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]),
    .dividend(av[0][7:0]), .divisor(bv[0][7:0]),
    .busy(bz0), .done(dn0), .quotient(q8), .remainder(r8),
    .div_by_zero(dz0), .overflow(ov0)
  );

  int_divider_seq #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut16 (
    .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm[1]),
    .dividend(av[1][15:0]), .divisor(bv[1][15:0]),
    .busy(bz1), .done(dn1), .quotient(q16), .remainder(r16),
    .div_by_zero(dz1), .overflow(ov1)
  );

  always_comb begin
    obz[0] = bz0; odn[0] = dn0; odz[0] = dz0; oov[0] = ov0;
    oq[0]  = 32'(q8);  orr[0] = 32'(r8);
    obz[1] = bz1; odn[1] = dn1; odz[1] = dz1; oov[1] = ov1;
    oq[1]  = 32'(q16); orr[1] = 32'(r16);
  end

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic bit sgn_en(input int i);
    return (i == 0);
  endfunction

  // Reference division straight from the arithmetic definition
  function automatic res_t ref_div(input int w, input bit sgn, input logic [31:0] a_in,
                                   input logic [31:0] b_in);
    res_t        o;
    longint      m, sa, sb;
    logic [31:0] a, b;
    m = (longint'(1) << w) - 1;
    a = a_in & 32'(m);
    b = b_in & 32'(m);
    o = '0;
    if (b == 0) begin
      o.q  = 32'(m);
      o.r  = a;
      o.dz = 1'b1;
    end else if (sgn) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      if (sa == -(longint'(1) << (w-1)) && sb == -1) begin
        o.q  = 32'(longint'(1) << (w-1));
        o.ov = 1'b1;
      end else begin
        o.q = 32'((sa / sb) & m);
        o.r = 32'((sa % sb) & m);
      end
    end else begin
      o.q = a / b;
      o.r = a % b;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] actv, input logic [31:0] expv);
    n_chk++;
    if (actv !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, actv, expv);
    end
  endtask

  // Model: which start is accepted, when done lands, which result is visible
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 1'b0;
        cur[i] = '0;
      end else begin
        if (act[i] && cyc == due[i]) cur[i] = pend[i];
        if (st[i] && !(act[i] && (cyc - 1) < due[i])) begin
          pend[i] = ref_div(wid(i), sgn_en(i) && sm[i], av[i], bv[i]);
          act[i]  = 1'b1;
          due[i]  = cyc + (pend[i].dz ? 1 : wid(i) + 1);
        end
      end
    end
  end

  // Per-cycle comparison of every output of both instances
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_busy", i), 32'(obz[i]), 32'(act[i] && cyc < due[i]));
        chk($sformatf("u%0d_done", i), 32'(odn[i]), 32'(act[i] && cyc == due[i]));
        chk($sformatf("u%0d_quotient", i), oq[i], cur[i].q);
        chk($sformatf("u%0d_remainder", i), orr[i], cur[i].r);
        chk($sformatf("u%0d_div_by_zero", i), 32'(odz[i]), 32'(cur[i].dz));
        chk($sformatf("u%0d_overflow", i), 32'(oov[i]), 32'(cur[i].ov));
      end
    end
  end

  // Issue one division and wait (bounded) for its done; returns on the done cycle
  task automatic op(input int i, input logic [31:0] a, input logic [31:0] b, input bit s,
                    output int lat, output int nbusy);
    av[i] = a; bv[i] = b; sm[i] = s; st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!odn[i] && lat < 200) begin
      if (obz[i]) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!odn[i]) chk("done_timeout", 32'(lat), 32'(0));
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (!odn[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!odn[i]) chk("wait_done_timeout", 32'(n), 32'(0));
  endtask

  function automatic logic [31:0] rnd_opnd(input int w);
    logic [31:0] m;
    m = 32'((longint'(1) << w) - 1);
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'(longint'(1) << (w-1));
      3:       return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    int lat, nb, ndone;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; sm[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(bz0), 32'd0);
    chk("reset_quotient", 32'(q8), 32'd0);
    chk("reset_done", 32'(dn0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op(0, 32'd200, 32'd7, 1'b0, lat, nb);
    chk("u200_7_latency", 32'(lat), 32'd9);
    chk("u200_7_busy_cycles", 32'(nb), 32'd9);
    chk("u200_7_q", 32'(q8), 32'd28);
    chk("u200_7_r", 32'(r8), 32'd4);

    op(0, 32'h9C, 32'd7, 1'b1, lat, nb);
    chk("sm100_7_q", 32'(q8), 32'hF2);
    chk("sm100_7_r", 32'(r8), 32'hFE);

    op(0, 32'd100, 32'hF9, 1'b1, lat, nb);
    chk("s100_m7_q", 32'(q8), 32'hF2);
    chk("s100_m7_r", 32'(r8), 32'h02);

    op(0, 32'h80, 32'hFF, 1'b1, lat, nb);
    chk("smin_m1_q", 32'(q8), 32'h80);
    chk("smin_m1_r", 32'(r8), 32'h00);
    chk("smin_m1_ov", 32'(ov0), 32'd1);

    op(0, 32'd255, 32'd1, 1'b0, lat, nb);
    chk("u255_1_q", 32'(q8), 32'hFF);
    chk("u255_1_ov", 32'(ov0), 32'd0);

    op(0, 32'd5, 32'd9, 1'b0, lat, nb);
    chk("u5_9_q", 32'(q8), 32'd0);
    chk("u5_9_r", 32'(r8), 32'd5);

    op(0, 32'd77, 32'd0, 1'b0, lat, nb);
    chk("dz_latency", 32'(lat), 32'd1);
    chk("dz_q", 32'(q8), 32'hFF);
    chk("dz_r", 32'(r8), 32'd77);
    chk("dz_flag", 32'(dz0), 32'd1);
    op(0, 32'd77, 32'd0, 1'b1, lat, nb);
    chk("dz_signed_r", 32'(r8), 32'd77);

    // start pulsed mid-calculation must be ignored
    av[0] = 32'd200; bv[0] = 32'd7; sm[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    av[0] = 32'd10; bv[0] = 32'd3; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0);
    chk("ignored_start_q", 32'(q8), 32'd28);
    chk("ignored_start_r", 32'(r8), 32'd4);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn0) ndone++;
    end
    chk("ignored_start_no_second_done", 32'(ndone), 32'd0);

    // back-to-back: second start issued in the done cycle
    op(0, 32'd200, 32'd7, 1'b0, lat, nb);
    op(0, 32'd100, 32'd7, 1'b0, lat, nb);
    chk("b2b_latency", 32'(lat), 32'd9);
    chk("b2b_q", 32'(q8), 32'd14);
    chk("b2b_r", 32'(r8), 32'd2);

    // reset in the fourth calculation cycle aborts without a done
    @(negedge clk);
    av[0] = 32'd200; bv[0] = 32'd7; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bz0), 32'd0);
    chk("abort_q", 32'(q8), 32'd0);
    chk("abort_r", 32'(r8), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn0) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    op(0, 32'd50, 32'd5, 1'b0, lat, nb);
    chk("post_reset_q", 32'(q8), 32'd10);
    chk("post_reset_r", 32'(r8), 32'd0);

    // start held high with operands changing every cycle
    st[0] = 1'b1;
    repeat (60) begin
      av[0] = rnd_opnd(8); bv[0] = rnd_opnd(8); sm[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    st[0] = 1'b0;
    repeat (12) @(negedge clk);

    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 1000; n++) begin
        op(0, rnd_opnd(8), rnd_opnd(8), 1'(m), lat, nb);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

    for (int n = 0; n < 1000; n++) begin
      op(1, rnd_opnd(16), rnd_opnd(16), 1'($urandom_range(0, 1)), lat, nb);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
